reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_if.sv | 37 +++
 rtl/reg_file.sv | 53 +++++
 tb/tb_reg_file.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// Register-file access bundle: write port, two operand read ports
// and the commit read port.
interface reg_file_if;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [4:0]  regCommitAddr_i;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;
  logic [63:0] regCommitReadData_o;

  modport master (
    output RegWrite,
    output WriteRegister,
    output WriteData,
    output ReadRegister1,
    output ReadRegister2,
    output regCommitAddr_i,
    input  ReadData1,
    input  ReadData2,
    input  regCommitReadData_o
  );

  modport slave (
    input  RegWrite,
    input  WriteRegister,
    input  WriteData,
    input  ReadRegister1,
    input  ReadRegister2,
    input  regCommitAddr_i,
    output ReadData1,
    output ReadData2,
    output regCommitReadData_o
  );
endinterface

// File: rtl/reg_file.sv
// 32 x 64-bit register file, index 31 hardwired to zero.
// One write port, three combinational read ports, no bypass.
module reg_file (
  input  logic  clk,
  input  logic  reset,
  reg_file_if.slave bus
);

  logic [63:0] regs_q [31];
  logic [63:0] regs_d [31];
  logic [30:0] wr_sel;

  // Index 31 has no storage, so it never matches a decoder output.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < 31; i++) begin
      wr_sel[i] = bus.RegWrite &&
                  (bus.WriteRegister == 5'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < 31; i++) begin
      regs_d[i] = wr_sel[i] ? bus.WriteData
                            : regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 31; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 31; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign bus.ReadData1 =
    (bus.ReadRegister1 == 5'd31) ? '0
      : regs_q[bus.ReadRegister1];

  assign bus.ReadData2 =
    (bus.ReadRegister2 == 5'd31) ? '0
      : regs_q[bus.ReadRegister2];

  assign bus.regCommitReadData_o =
    (bus.regCommitAddr_i == 5'd31) ? '0
      : regs_q[bus.regCommitAddr_i];

endmodule

// File: tb/tb_reg_file.sv
// Randomized bench for reg_file with an array-based reference model
// and directed checks with literal expectations.
module tb_reg_file;

  localparam logic [63:0] K = 64'h0000010204080001;

  logic clk;
  logic reset;
  reg_file_if bus ();

  reg_file u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;
  logic [63:0] m [32];

  function automatic logic [63:0] m_rd(input logic [4:0] a);
    return (a == 5'd31) ? 64'h0 : m[a];
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: state moves only on rising edges.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m[i] = 64'h0;
    end else if (bus.RegWrite && bus.WriteRegister != 5'd31) begin
      m[bus.WriteRegister] = bus.WriteData;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_rd1", bus.ReadData1, m_rd(bus.ReadRegister1));
      chk("cmp_rd2", bus.ReadData2, m_rd(bus.ReadRegister2));
      chk("cmp_cmt", bus.regCommitReadData_o,
          m_rd(bus.regCommitAddr_i));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    bus.RegWrite = 1'b1;
    bus.WriteRegister = a;
    bus.WriteData = d;
    step();
    bus.RegWrite = 1'b0;
  endtask

  task automatic rd_all(input string name,
                        input logic [4:0] a,
                        input logic [63:0] exp);
    bus.ReadRegister1 = a;
    bus.ReadRegister2 = a;
    bus.regCommitAddr_i = a;
    #1;
    chk({name, "_rd1"}, bus.ReadData1, exp);
    chk({name, "_rd2"}, bus.ReadData2, exp);
    chk({name, "_cmt"}, bus.regCommitReadData_o, exp);
  endtask

  initial begin
    logic [63:0] e;
    reset = 1'b0;
    bus.RegWrite = 1'b0;
    bus.WriteRegister = '0;
    bus.WriteData = '0;
    bus.ReadRegister1 = 5'd31;
    bus.ReadRegister2 = 5'd31;
    bus.regCommitAddr_i = 5'd31;

    // Index 31 reads zero even before any reset.
    #2;
    chk("prerst_rd1", bus.ReadData1, 64'h0);
    chk("prerst_rd2", bus.ReadData2, 64'h0);
    chk("prerst_cmt", bus.regCommitReadData_o, 64'h0);

    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_en = 1'b1;
    rd_all("rst", 5'd9, 64'h0);

    // Write in first cycle after reset release.
    wr(5'd3, 64'hDEAD_BEEF_0123_4567);
    rd_all("post_rst_wr", 5'd3, 64'hDEAD_BEEF_0123_4567);

    wr(5'd31, 64'hA0);
    rd_all("wr31", 5'd31, 64'h0);

    for (int i = 0; i < 31; i++) wr(5'(i), 64'(i) * K);
    bus.RegWrite = 1'b0;
    for (int j = 0; j < 32; j++) begin
      bus.WriteData = {$urandom, $urandom};
      bus.WriteRegister = 5'($urandom);
      e = (j == 31) ? 64'h0 : 64'(j) * K;
      rd_all("sweep", 5'(j), e);
      step();
    end

    for (int i = 0; i < 32; i++) wr(5'(i), '1);
    for (int j = 0; j < 32; j++) begin
      rd_all("ones", 5'(j), (j == 31) ? 64'h0 : '1);
      step();
    end
    for (int i = 0; i < 32; i++) wr(5'(i), '0);
    for (int j = 0; j < 32; j++) begin
      rd_all("zeros", 5'(j), 64'h0);
      step();
    end

    wr(5'd15, 64'h0F0F_0000_FFFF_1234);
    wr(5'd16, 64'h1415111431181D1C);
    bus.WriteData = 64'h463EA1574938EF1C;
    bus.WriteRegister = 5'd16;
    step();
    rd_all("hold16", 5'd16, 64'h1415111431181D1C);
    #1 bus.RegWrite = 1'b1;
    #1 bus.RegWrite = 1'b0;
    step();
    rd_all("pulse16", 5'd16, 64'h1415111431181D1C);
    #1 bus.ReadRegister2 = 5'd15;
    #1 chk("mid_rr2", bus.ReadData2, 64'h0F0F_0000_FFFF_1234);
    step();

    wr(5'd7, 64'h7777_0000_0000_0001);
    bus.ReadRegister1 = 5'd7;
    bus.RegWrite = 1'b1;
    bus.WriteRegister = 5'd7;
    bus.WriteData = 64'h7777_0000_0000_0002;
    #1 chk("nobypass_old", bus.ReadData1, 64'h7777_0000_0000_0001);
    step();
    bus.RegWrite = 1'b0;
    chk("nobypass_new", bus.ReadData1, 64'h7777_0000_0000_0002);

    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      bus.RegWrite = $urandom_range(0, 1);
      bus.WriteRegister = 5'($urandom);
      bus.WriteData = {$urandom, $urandom};
      bus.ReadRegister1 = 5'($urandom);
      bus.ReadRegister2 = 5'($urandom);
      bus.regCommitAddr_i = 5'($urandom);
      step();
    end
    reset = 1'b0;

    for (int i = 0; i < 31; i++) wr(5'(i), {$urandom, $urandom});
    reset = 1'b1;
    bus.RegWrite = 1'b1;
    bus.WriteRegister = 5'd5;
    bus.WriteData = 64'h1234;
    step();
    reset = 1'b0;
    bus.RegWrite = 1'b0;
    for (int j = 0; j < 32; j++) begin
      rd_all("rst_prio", 5'(j), 64'h0);
      step();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
